// File: rtl/servo_pwm_gen_if.sv
// Servo PWM generator port bundle: position/enable in, pulse and status out.
// The slave modport is the generator; the master modport is whoever feeds it.
interface servo_pwm_gen_if #(
  parameter int N = 8
);
  logic [N-1:0] data;
  logic         en;
  logic         pwm;
  logic         frame_start;
  logic         busy;

  modport master (output data, en, input pwm, frame_start, busy);
  modport slave  (input data, en, output pwm, frame_start, busy);
endinterface

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: turns a position word into a clamped high pulse inside a
// fixed-length frame. Frames start only when enabled, and a started frame always completes.
module servo_pwm_gen #(
  parameter int N          = 8,
  parameter int PERIOD_CYC = 200000,
  parameter int MIN_CYC    = 10000,
  parameter int STEP_CYC   = 39,
  parameter int MAX_CYC    = 20000
) (
  input  logic            clk,
  input  logic            reset,
  servo_pwm_gen_if.slave  bus
);

  localparam int              CW       = $clog2(PERIOD_CYC + 1);
  localparam logic [CW-1:0]   PERIOD_C = CW'(PERIOD_CYC);
  localparam logic [CW-1:0]   MAX_C    = CW'(MAX_CYC);
  localparam logic [31:0]     MAX_W    = 32'(MAX_CYC);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  logic [1:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] r_width_q, w_width_nxt;
  logic          r_pwm, w_pwm_nxt;
  logic          r_frame_start, w_frame_start_nxt;

  logic [31:0]   w_width_raw;
  logic [CW-1:0] w_width_clamped;
  logic          w_start;

  // Full 32-bit width so a large data*STEP product clamps instead of wrapping.
  assign w_width_raw     = 32'(MIN_CYC) + 32'(bus.data) * 32'(STEP_CYC);
  assign w_width_clamped = (w_width_raw > MAX_W) ? MAX_C : CW'(w_width_raw);

  // A frame may begin only from IDLE or exactly at the end of the previous frame.
  assign w_start = bus.en && ((r_state == IDLE) ||
                              ((r_state == LOW) && (r_cnt == PERIOD_C)));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_width_nxt       = r_width_q;
    w_pwm_nxt         = 1'b0;
    w_frame_start_nxt = 1'b0;

    if (w_start) begin
      w_state_nxt       = HIGH;
      w_cnt_nxt         = CW'(1);
      w_width_nxt       = w_width_clamped;
      w_pwm_nxt         = 1'b1;
      w_frame_start_nxt = 1'b1;
    end else begin
      case (r_state)
        IDLE: w_cnt_nxt = '0;
        HIGH: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == r_width_q) w_state_nxt = LOW;
          else                    w_pwm_nxt   = 1'b1;
        end
        LOW: begin
          if (r_cnt == PERIOD_C) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_width_q     <= '0;
      r_pwm         <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_width_q     <= w_width_nxt;
      r_pwm         <= w_pwm_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign bus.pwm         = r_pwm;
  assign bus.frame_start = r_frame_start;
  assign bus.busy        = (r_state != IDLE);

endmodule
